// File: rtl/k12a_lcd_responder_pkg.sv
// Shared types and constants for the k12a HD44780-style LCD responder.
// Command bit positions, line bases and AC stepping helpers.
package k12a_lcd_responder_pkg;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_CLEARING,
    S_BUSY
  } lcd_resp_state_t;

  localparam int CMD_CLEAR_BIT = 0;
  localparam int CMD_HOME_BIT  = 1;
  localparam int CMD_ENTRY_BIT = 2;
  localparam int CMD_DISP_BIT  = 3;
  localparam int CMD_SHIFT_BIT = 4;
  localparam int CMD_FUNC_BIT  = 5;
  localparam int CMD_CGRAM_BIT = 6;
  localparam int CMD_DDRAM_BIT = 7;

  localparam int ENTRY_ID_BIT = 1;
  localparam int DISP_D_BIT   = 2;
  localparam int DISP_C_BIT   = 1;
  localparam int DISP_B_BIT   = 0;
  localparam int SHIFT_SC_BIT = 3;
  localparam int SHIFT_RL_BIT = 2;
  localparam int FUNC_DL_BIT  = 4;

  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int DDRAM_DEPTH = 32;

  // Lines are 16 wide; stepping past either end jumps to the other line.
  function automatic logic [6:0] ac_step(
    input logic [6:0] ac,
    input logic       inc
  );
    logic [6:0] r;
    if (inc) begin
      if (ac[3:0] == 4'hF)
        r = ac[6] ? LINE1_BASE : LINE2_BASE;
      else
        r = ac + 7'd1;
    end else begin
      if (ac[3:0] == 4'h0)
        r = ac[6] ? (LINE1_BASE | 7'h0F)
                  : (LINE2_BASE | 7'h0F);
      else
        r = ac - 7'd1;
    end
    return r;
  endfunction

  function automatic logic [7:0] msb_onehot(
    input logic [7:0] d
  );
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++)
      if (d[i]) r = 8'h01 << i;
    return r;
  endfunction

endpackage

// File: rtl/k12a_lcd_ddram.sv
// 32x8 character RAM for the LCD responder.
// One synchronous write port, two asynchronous read ports.
module k12a_lcd_ddram
  import k12a_lcd_responder_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [7:0] wdata,
  input  logic [4:0] raddr_a,
  output logic [7:0] rdata_a,
  input  logic [4:0] raddr_b,
  output logic [7:0] rdata_b
);

  logic [7:0] mem_q [DDRAM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/k12a_lcd_responder.sv
// HD44780-style LCD bus responder: sync, strobe detect, decode,
// address counter, busy timing and a 2x16 DDRAM.
module k12a_lcd_responder
  import k12a_lcd_responder_pkg::*;
#(
  parameter int BUSY_CYCLES  = 37,
  parameter int CLEAR_CYCLES = 1520,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       sys_clock,
  input  logic       reset_n,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_data_in,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [4:0] char_addr,
  output logic [7:0] char_data,
  output logic       busy,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic [6:0] ddram_addr,
  output logic       protocol_error
);

  localparam int CMAX =
    (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] N_BUSY  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] N_CLEAR = CW'(CLEAR_CYCLES);

  logic [SYNC_STAGES-1:0][10:0] sync_q, sync_d;
  logic [10:0] bus_s;
  logic        rs_s, rw_s, en_s;
  logic [7:0]  data_s;
  logic        en_prev_q;
  logic        strobe, wr_stb, rd_stb;

  lcd_resp_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    fill_q, fill_d;
  logic [6:0]    ac_q, ac_d;
  logic id_q, id_d, cg_q, cg_d;
  logic disp_q, disp_d, cur_q, cur_d;
  logic blink_q, blink_d, err_q, err_d;

  logic       ram_we;
  logic [4:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [7:0] bus_rdata;
  logic [7:0] hot;

  assign sync_d = {sync_q[SYNC_STAGES-2:0],
                   {lcd_rs, lcd_rw, lcd_en, lcd_data_in}};
  assign bus_s  = sync_q[SYNC_STAGES-1];
  assign rs_s   = bus_s[10];
  assign rw_s   = bus_s[9];
  assign en_s   = bus_s[8];
  assign data_s = bus_s[7:0];

  assign strobe = en_prev_q & ~en_s;
  assign wr_stb = strobe & ~rw_s;
  assign rd_stb = strobe & rw_s;
  assign busy   = (state_q != S_IDLE);
  assign hot    = msb_onehot(data_s);

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      en_prev_q <= 1'b0;
      state_q   <= S_INIT;
      cnt_q     <= N_CLEAR;
      fill_q    <= 6'd0;
      ac_q      <= LINE1_BASE;
      id_q      <= 1'b1;
      cg_q      <= 1'b0;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      blink_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      en_prev_q <= en_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      ac_q      <= ac_d;
      id_q      <= id_d;
      cg_q      <= cg_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      blink_q   <= blink_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    ac_d      = ac_q;
    id_d      = id_q;
    cg_d      = cg_q;
    disp_d    = disp_q;
    cur_d     = cur_q;
    blink_d   = blink_q;
    err_d     = err_q;
    ram_we    = 1'b0;
    ram_waddr = {ac_q[6], ac_q[3:0]};
    ram_wdata = data_s;

    // Fill runs alongside the busy countdown; CLEAR_CYCLES >= 32.
    unique case (state_q)
      S_INIT, S_CLEARING: begin
        if (!fill_q[5]) begin
          ram_we    = 1'b1;
          ram_waddr = fill_q[4:0];
          ram_wdata = BLANK_CHAR;
          fill_d    = fill_q + 6'd1;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1))
          state_d = S_IDLE;
        else if (state_q == S_CLEARING && fill_q == 6'd31)
          state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) state_d = S_IDLE;
      end
      S_IDLE: ;
      default: state_d = S_INIT;
    endcase

    if (wr_stb && busy) err_d = 1'b1;
    if (rd_stb && rs_s && busy) err_d = 1'b1;

    if (rd_stb && rs_s && !busy && !cg_q)
      ac_d = ac_step(ac_q, id_q);

    if (wr_stb && !busy) begin
      state_d = S_BUSY;
      cnt_d   = N_BUSY;
      if (rs_s) begin
        if (!cg_q) begin
          ram_we = 1'b1;
          ac_d   = ac_step(ac_q, id_q);
        end
      end else begin
        unique case (1'b1)
          hot[CMD_DDRAM_BIT]: begin
            ac_d = data_s[6:0];
            cg_d = 1'b0;
            if (data_s[5:4] != 2'b00) err_d = 1'b1;
          end
          hot[CMD_CGRAM_BIT]: cg_d = 1'b1;
          hot[CMD_FUNC_BIT]: begin
            if (!data_s[FUNC_DL_BIT]) err_d = 1'b1;
          end
          hot[CMD_SHIFT_BIT]: begin
            if (!data_s[SHIFT_SC_BIT])
              ac_d = ac_step(ac_q, data_s[SHIFT_RL_BIT]);
          end
          hot[CMD_DISP_BIT]: begin
            disp_d  = data_s[DISP_D_BIT];
            cur_d   = data_s[DISP_C_BIT];
            blink_d = data_s[DISP_B_BIT];
          end
          hot[CMD_ENTRY_BIT]: id_d = data_s[ENTRY_ID_BIT];
          hot[CMD_HOME_BIT]: begin
            ac_d  = LINE1_BASE;
            cnt_d = N_CLEAR;
          end
          hot[CMD_CLEAR_BIT]: begin
            ac_d    = LINE1_BASE;
            id_d    = 1'b1;
            cnt_d   = N_CLEAR;
            fill_d  = 6'd0;
            state_d = S_CLEARING;
          end
          default: ;
        endcase
      end
    end
  end

  k12a_lcd_ddram u_ddram (
    .clk     (sys_clock),
    .we      (ram_we),
    .waddr   (ram_waddr),
    .wdata   (ram_wdata),
    .raddr_a ({ac_q[6], ac_q[3:0]}),
    .rdata_a (bus_rdata),
    .raddr_b (char_addr),
    .rdata_b (char_data)
  );

  always_comb begin
    lcd_data_oe  = en_s & rw_s;
    lcd_data_out = 8'h00;
    if (lcd_data_oe) begin
      if (!rs_s)
        lcd_data_out = {busy, ac_q};
      else if (!cg_q)
        lcd_data_out = bus_rdata;
    end
  end

  assign display_on     = disp_q;
  assign cursor_on      = cur_q;
  assign blink_on       = blink_q;
  assign ddram_addr     = ac_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_k12a_lcd_responder.sv
// Directed bench for k12a_lcd_responder.
// Checks reset timing, writes, wrap, busy rejection and reset abort.
module tb_k12a_lcd_responder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic [7:0] lcd_data_out;
  logic       lcd_data_oe;
  logic [4:0] char_addr = 5'd0;
  logic [7:0] char_data;
  logic       busy;
  logic       display_on, cursor_on, blink_on;
  logic [6:0] ddram_addr;
  logic       protocol_error;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  k12a_lcd_responder dut (
    .sys_clock      (clk),
    .reset_n        (reset_n),
    .lcd_rs         (lcd_rs),
    .lcd_rw         (lcd_rw),
    .lcd_en         (lcd_en),
    .lcd_data_in    (lcd_data_in),
    .lcd_data_out   (lcd_data_out),
    .lcd_data_oe    (lcd_data_oe),
    .char_addr      (char_addr),
    .char_data      (char_data),
    .busy           (busy),
    .display_on     (display_on),
    .cursor_on      (cursor_on),
    .blink_on       (blink_on),
    .ddram_addr     (ddram_addr),
    .protocol_error (protocol_error)
  );

  task automatic check(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    lcd_data_in = d;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {15'd0, busy}, 16'd0);
  endtask

  task automatic peek(input string tag, input logic [4:0] a,
                      input logic [7:0] exp);
    char_addr = a;
    #1;
    check(tag, {8'd0, char_data}, {8'd0, exp});
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {15'd0, busy}, 16'd1);
    check("rst_addr", {9'd0, ddram_addr}, 16'd0);
    check("rst_disp", {13'd0, display_on, cursor_on, blink_on}, 16'd0);
    check("rst_err", {15'd0, protocol_error}, 16'd0);
    check("rst_oe", {15'd0, lcd_data_oe}, 16'd0);
    check("rst_out", {8'd0, lcd_data_out}, 16'd0);

    reset_n = 1'b1;
    n = 0;
    while (n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (busy !== 1'b1) break;
    end
    check("init_busy_len", 16'(n), 16'd1520);

    for (int i = 0; i < 32; i++) peek("blank_fill", 5'(i), 8'h20);
    check("init_disp", {15'd0, display_on}, 16'd0);

    bus_write(1'b0, 8'h38); wait_idle();
    bus_write(1'b0, 8'h0F); wait_idle();
    bus_write(1'b0, 8'h06); wait_idle();
    bus_write(1'b1, 8'h48); wait_idle();
    bus_write(1'b1, 8'h69); wait_idle();
    peek("hi_0", 5'd0, 8'h48);
    peek("hi_1", 5'd1, 8'h69);
    check("hi_addr", {9'd0, ddram_addr}, 16'h02);
    check("hi_dcb", {13'd0, display_on, cursor_on, blink_on}, 16'h7);
    check("hi_err", {15'd0, protocol_error}, 16'd0);

    bus_write(1'b0, 8'h8F); wait_idle();
    bus_write(1'b1, 8'h41); wait_idle();
    bus_write(1'b1, 8'h42); wait_idle();
    peek("wrap_15", 5'd15, 8'h41);
    peek("wrap_16", 5'd16, 8'h42);
    check("wrap_addr", {9'd0, ddram_addr}, 16'h41);

    bus_write(1'b0, 8'h04); wait_idle();
    bus_write(1'b0, 8'hC0); wait_idle();
    bus_write(1'b1, 8'h5A); wait_idle();
    peek("dec_16", 5'd16, 8'h5A);
    check("dec_addr", {9'd0, ddram_addr}, 16'h0F);

    bus_write(1'b1, 8'h51);
    bus_write(1'b1, 8'h58);
    peek("drop_15", 5'd15, 8'h51);
    peek("drop_14", 5'd14, 8'h20);
    check("drop_addr", {9'd0, ddram_addr}, 16'h0E);
    check("drop_err", {15'd0, protocol_error}, 16'd1);

    @(negedge clk);
    lcd_rs = 1'b0;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    check("stat_oe", {15'd0, lcd_data_oe}, 16'd1);
    check("stat_val", {8'd0, lcd_data_out}, 16'h8E);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    wait_idle();

    lcd_rs = 1'b1;
    lcd_rw = 1'b1;
    lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    check("rd_data", {8'd0, lcd_data_out}, 16'h20);
    lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    check("rd_step", {9'd0, ddram_addr}, 16'h0D);
    check("rd_busy", {15'd0, busy}, 16'd0);
    lcd_rw = 1'b0;

    reset_n = 1'b0;
    @(negedge clk);
    check("rst2_err", {15'd0, protocol_error}, 16'd0);
    reset_n = 1'b1;
    wait_idle();

    bus_write(1'b0, 8'h20);
    check("fs4_err", {15'd0, protocol_error}, 16'd1);
    wait_idle();
    bus_write(1'b0, 8'h90);
    check("bad_ac_err", {15'd0, protocol_error}, 16'd1);
    check("bad_ac_addr", {9'd0, ddram_addr}, 16'h10);
    check("bad_ac_busy", {15'd0, busy}, 16'd1);

    reset_n = 1'b0;
    @(negedge clk);
    check("abort_err", {15'd0, protocol_error}, 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd1);
    check("abort_addr", {9'd0, ddram_addr}, 16'd0);
    check("abort_disp", {15'd0, display_on}, 16'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_rebusy", {15'd0, busy}, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
